// File: rtl/aes_arbiter.sv
// Round-robin front end for a single aes core: grants one requester job at a time,
// waits out the core latency, and returns the tagged ciphertext on one response port.
//
// state | meaning
// IDLE  | no job in flight; grants and issues to the core in the same cycle
// RUN   | job issued, counting cycles until the core result (or watchdog abort)
// HOLD  | ciphertext captured, rsp_valid_o high until the consumer accepts
module aes_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int LAT     = 11,
  parameter int WDOG    = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*128-1:0] req_data_i,
  input  logic [NUM_REQ*128-1:0] req_key_i,
  output logic                   core_valid_o,
  output logic [127:0]           core_data_o,
  output logic [127:0]           core_key_o,
  input  logic [127:0]           core_res_i,
  input  logic                   core_res_valid_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [127:0]           rsp_data_o,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int CW = 5;
  localparam int IW = ID_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [127:0]    rsp_data_q, rsp_data_d;
  logic            err_q, err_d;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [IW-1:0]   scan_idx;
  logic            issue;

  // Search upward from rr_ptr with wrap-around; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + IW'(i);
      if (scan_idx >= IW'(NUM_REQ)) begin
        scan_idx = scan_idx - IW'(NUM_REQ);
      end
      if (!gnt_found && req_valid_i[scan_idx[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  // The core shares resetn, so nothing is issued while reset is asserted.
  assign issue = resetn && (state_q == S_IDLE) && gnt_found;

  always_comb begin
    req_ready_o = '0;
    core_data_o = '0;
    core_key_o  = '0;
    if (issue) begin
      req_ready_o[gnt_idx] = 1'b1;
      core_data_o          = req_data_i[int'(gnt_idx)*128 +: 128];
      core_key_o           = req_key_i[int'(gnt_idx)*128 +: 128];
    end
  end

  assign core_valid_o = issue;
  assign rsp_valid_o  = (state_q == S_HOLD);
  assign busy_o       = (state_q != S_IDLE);
  assign rsp_data_o   = rsp_data_q;
  assign rsp_id_o     = rsp_id_q;
  assign err_o        = err_q;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (core_res_valid_i) begin
          err_d = 1'b1;
        end
        if (issue) begin
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          // cnt holds the index of the current RUN cycle, so the first RUN cycle reads 1.
          cnt_d    = CW'(1);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (core_res_valid_i) begin
          rsp_data_d = core_res_i;
          rsp_id_d   = id_q;
          state_d    = S_HOLD;
          if (cnt_q != CW'(LAT)) begin
            err_d = 1'b1;
          end
        end else if (cnt_q >= CW'(WDOG)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (core_res_valid_i) begin
          err_d = 1'b1;
        end
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_arbiter.sv
// Directed bench for aes_arbiter; the bench plays the aes core as a stub with
// programmable result latency and checks grants, responses and error handling.
module tb_aes_arbiter;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int LATC = 11;

  logic             clk;
  logic             resetn;
  logic [N-1:0]     req_valid_i;
  logic [N-1:0]     req_ready_o;
  logic [N*128-1:0] req_data_i;
  logic [N*128-1:0] req_key_i;
  logic             core_valid_o;
  logic [127:0]     core_data_o;
  logic [127:0]     core_key_o;
  logic [127:0]     core_res_i;
  logic             core_res_valid_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [127:0]     rsp_data_o;
  logic [IDW-1:0]   rsp_id_o;
  logic             busy_o;
  logic             err_o;

  aes_arbiter #(.NUM_REQ(N), .ID_W(IDW), .LAT(LATC), .WDOG(16)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_data_i       (req_data_i),
    .req_key_i        (req_key_i),
    .core_valid_o     (core_valid_o),
    .core_data_o      (core_data_o),
    .core_key_o       (core_key_o),
    .core_res_i       (core_res_i),
    .core_res_valid_i (core_res_valid_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_data_o       (rsp_data_o),
    .rsp_id_o         (rsp_id_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [127:0] dat [N];
  logic [127:0] key [N];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load();
    for (int i = 0; i < N; i++) begin
      req_data_i[i*128 +: 128] = dat[i];
      req_key_i[i*128 +: 128]  = key[i];
    end
  endtask

  // Stand-in for the core transform; any data/key dependent function will do.
  function automatic logic [127:0] stub_res(input logic [127:0] d, input logic [127:0] k);
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_c3c3_a5a5_f0f0_6969_9696;
  endfunction

  // Waits (bounded) for an issue and checks it belongs to requester g.
  task automatic wait_grant(input int g, output int t);
    logic got;
    got = 1'b0;
    t   = -1;
    for (int n = 0; n < 30; n++) begin
      #1;
      if (core_valid_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("grant_seen", got, 1'b1);
    if (got) begin
      t = cyc;
      chk("grant_ready", req_ready_o, 128'(1) << g);
      chk("grant_data", core_data_o, dat[g]);
      chk("grant_key", core_key_o, key[g]);
      chk("grant_busy", busy_o, 1'b0);
    end
  endtask

  // Called in the issue cycle T; returns the result at T+lat and ends in T+lat+1.
  task automatic serve(input int lat, input logic [127:0] res, input int id,
                       input logic [N-1:0] valid_after);
    for (int i = 1; i <= lat; i++) begin
      tick();
      if (i == 1) begin
        req_valid_i = valid_after;
        #1;
        chk("run_core_valid", core_valid_o, 1'b0);
        chk("run_busy", busy_o, 1'b1);
        chk("run_ready", req_ready_o, '0);
      end
    end
    core_res_valid_i = 1'b1;
    core_res_i       = res;
    #1;
    chk("pre_rsp_valid", rsp_valid_o, 1'b0);
    tick();
    core_res_valid_i = 1'b0;
    core_res_i       = '0;
    #1;
    chk("rsp_valid", rsp_valid_o, 1'b1);
    chk("rsp_data", rsp_data_o, res);
    chk("rsp_id", rsp_id_o, 128'(id));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int prev_t;
    int g;
    int hs;
    logic seen;
    logic [127:0] exp_bp;

    resetn           = 1'b0;
    req_valid_i      = '0;
    req_data_i       = '0;
    req_key_i        = '0;
    core_res_i       = '0;
    core_res_valid_i = 1'b0;
    rsp_ready_i      = 1'b0;
    prev_t           = 0;
    for (int i = 0; i < N; i++) begin
      dat[i] = {16{8'(8'h11 * (i + 1))}};
      key[i] = {16{8'(8'ha0 + i)}};
    end
    load();
    repeat (3) tick();

    // reset state, with requests present while reset is held
    req_valid_i = '1;
    #1;
    chk("rst_req_ready", req_ready_o, '0);
    chk("rst_core_valid", core_valid_o, 1'b0);
    chk("rst_core_data", core_data_o, '0);
    chk("rst_core_key", core_key_o, '0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_data", rsp_data_o, '0);
    chk("rst_rsp_id", rsp_id_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    req_valid_i = '0;
    resetn      = 1'b1;
    tick();

    // all requesters valid: grants 0,1,2,3,0 spaced 13 cycles
    rsp_ready_i = 1'b1;
    req_valid_i = '1;
    for (int j = 0; j < 5; j++) begin
      g = j % N;
      wait_grant(g, t);
      if (j > 0) chk("rr_spacing", 128'(t - prev_t), 128'd13);
      prev_t = t;
      serve(LATC, stub_res(dat[g], key[g]), g, '1);
      tick();
    end

    // FIPS-197 vector from requester 2
    req_valid_i = '0;
    dat[2] = 128'h00112233445566778899aabbccddeeff;
    key[2] = 128'h000102030405060708090a0b0c0d0e0f;
    load();
    req_valid_i = 4'b0100;
    wait_grant(2, t);
    serve(LATC, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2, '0);
    chk("fips_data", rsp_data_o, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("fips_err", err_o, 1'b0);
    tick();
    #1;
    chk("fips_idle_busy", busy_o, 1'b0);
    chk("fips_idle_rsp", rsp_valid_o, 1'b0);

    // backpressure: requester 3 wins from ptr 3, requester 0 waits through HOLD
    rsp_ready_i = 1'b0;
    req_valid_i = 4'b1001;
    exp_bp      = stub_res(dat[3], key[3]);
    wait_grant(3, t);
    serve(LATC, exp_bp, 3, 4'b0001);
    for (int k = 0; k < 20; k++) begin
      tick();
      #1;
      chk("bp_valid", rsp_valid_o, 1'b1);
      chk("bp_data", rsp_data_o, exp_bp);
      chk("bp_id", rsp_id_o, 128'd3);
      chk("bp_req_ready", req_ready_o, '0);
      chk("bp_core_valid", core_valid_o, 1'b0);
    end
    rsp_ready_i = 1'b1;
    hs = cyc;
    tick();
    wait_grant(0, t);
    chk("bp_idle_next", 128'(t - hs), 128'd1);
    serve(LATC, stub_res(dat[0], key[0]), 0, '0);
    chk("bp_err", err_o, 1'b0);
    tick();

    // early result at cnt=9: delivered, err sticky
    req_valid_i = 4'b0010;
    wait_grant(1, t);
    chk("early_err_before", err_o, 1'b0);
    serve(9, stub_res(dat[1], key[1]), 1, '0);
    chk("early_err", err_o, 1'b1);
    tick();
    #1;
    chk("early_idle", busy_o, 1'b0);
    repeat (3) tick();
    chk("early_err_sticky", err_o, 1'b1);

    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    chk("rst2_err", err_o, 1'b0);
    tick();

    // watchdog: no result ever returned
    req_valid_i = 4'b0100;
    wait_grant(2, t);
    seen = 1'b0;
    tick();
    req_valid_i = '0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) tick();
      #1;
      if (rsp_valid_o === 1'b1) seen = 1'b1;
    end
    chk("wd_busy_last", busy_o, 1'b1);
    chk("wd_err_pre", err_o, 1'b0);
    tick();
    #1;
    chk("wd_idle", busy_o, 1'b0);
    chk("wd_err", err_o, 1'b1);
    chk("wd_rsp_valid", rsp_valid_o, 1'b0);
    chk("wd_no_rsp", seen, 1'b0);

    // reset pulse at T+5 of a job, then fresh job granted from requester 0
    req_valid_i = 4'b0010;
    wait_grant(1, t);
    repeat (5) tick();
    req_valid_i = '0;
    resetn      = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    chk("mr_busy", busy_o, 1'b0);
    chk("mr_err", err_o, 1'b0);
    chk("mr_rsp_valid", rsp_valid_o, 1'b0);
    chk("mr_rsp_data", rsp_data_o, '0);
    chk("mr_rsp_id", rsp_id_o, '0);
    chk("mr_req_ready", req_ready_o, '0);
    chk("mr_core_valid", core_valid_o, 1'b0);
    req_valid_i = '1;
    wait_grant(0, t);
    serve(LATC, stub_res(dat[0], key[0]), 0, '0);
    chk("mr_err_after", err_o, 1'b0);
    tick();
    #1;
    chk("mr_idle", busy_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
